// File: rtl/video_capture_dma_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// video_capture_dma_if : 24-bit pixel stream in + AXI4 write-only memory bus
// Revision : 1.0
// -----------------------------------------------------------------------------
interface video_capture_dma_if;
  logic        in_axis_tvalid;
  logic        in_axis_tready;
  logic [23:0] in_axis_tdata;
  logic        in_axis_tuser;

  logic [31:0] mem_axi_awaddr;
  logic [7:0]  mem_axi_awlen;
  logic [2:0]  mem_axi_awsize;
  logic [1:0]  mem_axi_awburst;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_wlast;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [1:0]  mem_axi_bresp;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;

  modport master (
    input  in_axis_tvalid, in_axis_tdata, in_axis_tuser,
    output in_axis_tready,
    output mem_axi_awaddr, mem_axi_awlen, mem_axi_awsize, mem_axi_awburst,
    output mem_axi_awprot, mem_axi_awvalid,
    input  mem_axi_awready,
    output mem_axi_wdata, mem_axi_wstrb, mem_axi_wlast, mem_axi_wvalid,
    input  mem_axi_wready,
    input  mem_axi_bresp, mem_axi_bvalid,
    output mem_axi_bready
  );

  modport slave (
    output in_axis_tvalid, in_axis_tdata, in_axis_tuser,
    input  in_axis_tready,
    input  mem_axi_awaddr, mem_axi_awlen, mem_axi_awsize, mem_axi_awburst,
    input  mem_axi_awprot, mem_axi_awvalid,
    output mem_axi_awready,
    input  mem_axi_wdata, mem_axi_wstrb, mem_axi_wlast, mem_axi_wvalid,
    output mem_axi_wready,
    output mem_axi_bresp, mem_axi_bvalid,
    input  mem_axi_bready
  );
endinterface
`default_nettype wire

// File: rtl/video_capture_dma.sv
`default_nettype none
// -----------------------------------------------------------------------------
// video_capture_dma : captures whole video frames into memory as 32-bit words
// Revision : 1.0
// -----------------------------------------------------------------------------
module video_capture_dma #(
  parameter int HOR_PIXELS    = 1920,
  parameter int VER_PIXELS    = 1080,
  parameter int MEM_BURST_LEN = 16,
  parameter int FIFO_DEPTH    = 64
) (
  input  wire                 oclk,
  input  wire                 resetn,
  input  wire  [31:0]         cfg_startaddr,
  video_capture_dma_if.master bus,
  output logic                frame_done,
  output logic                busy,
  output logic                sof_err,
  output logic                resp_err
);

  localparam int NUM_PIXELS      = HOR_PIXELS * VER_PIXELS;
  localparam int NUM_BURSTS      = (NUM_PIXELS + MEM_BURST_LEN - 1) / MEM_BURST_LEN;
  localparam int PIX_W           = $clog2(NUM_PIXELS + 1);
  localparam int BIDX_W          = $clog2(NUM_BURSTS + 1);
  localparam int BEAT_W          = $clog2(MEM_BURST_LEN);
  localparam int PTR_W           = $clog2(FIFO_DEPTH);
  localparam int CNT_W           = PTR_W + 1;
  localparam int BYTES_PER_BURST = MEM_BURST_LEN * 4;

  typedef enum logic [1:0] {IN_SYNC, IN_CAPTURE, IN_FLUSH} in_state_e;
  typedef enum logic [1:0] {BU_IDLE, BU_AW, BU_W, BU_B} bu_state_e;

  // ---------------- pixel FIFO (first-word-fall-through) ----------------
  logic [23:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);

  always_ff @(posedge oclk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= bus.in_axis_tdata;
  end

  always_ff @(posedge oclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------- input FSM ----------------
  in_state_e        in_state_q, in_state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [31:0]      base_q, base_d;
  logic             sof_err_q, sof_err_d;
  logic             tready_en_q;
  logic             frame_done_q;

  always_comb begin
    in_state_d         = in_state_q;
    pix_cnt_d          = pix_cnt_q;
    base_d             = base_q;
    sof_err_d          = sof_err_q;
    fifo_push          = 1'b0;
    bus.in_axis_tready = 1'b0;
    case (in_state_q)
      IN_SYNC: begin
        bus.in_axis_tready = tready_en_q;
        if (tready_en_q && bus.in_axis_tvalid && bus.in_axis_tuser && (cfg_startaddr != '0)) begin
          fifo_push  = 1'b1;
          base_d     = cfg_startaddr;
          pix_cnt_d  = PIX_W'(1);
          in_state_d = (NUM_PIXELS == 1) ? IN_FLUSH : IN_CAPTURE;
        end
      end
      IN_CAPTURE: begin
        bus.in_axis_tready = !fifo_full;
        if (bus.in_axis_tvalid && !fifo_full) begin
          fifo_push = 1'b1;
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (bus.in_axis_tuser) sof_err_d = 1'b1;
          if (pix_cnt_q == PIX_W'(NUM_PIXELS - 1)) in_state_d = IN_FLUSH;
        end
      end
      IN_FLUSH: begin
        bus.in_axis_tready = 1'b1;
        if (frame_done_q) in_state_d = IN_SYNC;
      end
      default: in_state_d = IN_SYNC;
    endcase
  end

  always_ff @(posedge oclk or negedge resetn) begin
    if (!resetn) begin
      in_state_q  <= IN_SYNC;
      pix_cnt_q   <= '0;
      base_q      <= '0;
      sof_err_q   <= 1'b0;
      tready_en_q <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      pix_cnt_q   <= pix_cnt_d;
      base_q      <= base_d;
      sof_err_q   <= sof_err_d;
      tready_en_q <= 1'b1;
    end
  end

  // ---------------- burst FSM ----------------
  bu_state_e         bu_state_q, bu_state_d;
  logic [BIDX_W-1:0] burst_idx_q, burst_idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic              frame_done_d, resp_err_q, resp_err_d;
  logic              last_beat;

  assign last_beat = (beat_q == BEAT_W'(MEM_BURST_LEN - 1));

  always_comb begin
    bu_state_d   = bu_state_q;
    burst_idx_d  = burst_idx_q;
    beat_d       = beat_q;
    awaddr_d     = awaddr_q;
    frame_done_d = 1'b0;
    resp_err_d   = resp_err_q;
    fifo_pop     = 1'b0;
    case (bu_state_q)
      BU_IDLE: begin
        // A partial burst is only allowed once the frame's input is complete.
        if ((fifo_cnt_q >= CNT_W'(MEM_BURST_LEN)) || ((in_state_q == IN_FLUSH) && !fifo_empty)) begin
          bu_state_d = BU_AW;
          awaddr_d   = base_q + 32'(burst_idx_q) * 32'(BYTES_PER_BURST);
        end
      end
      BU_AW: begin
        beat_d = '0;
        if (bus.mem_axi_awready) bu_state_d = BU_W;
      end
      BU_W: begin
        if (bus.mem_axi_wready) begin
          fifo_pop = !fifo_empty;
          beat_d   = beat_q + 1'b1;
          if (last_beat) begin
            beat_d     = '0;
            bu_state_d = BU_B;
          end
        end
      end
      BU_B: begin
        if (bus.mem_axi_bvalid) begin
          if (bus.mem_axi_bresp != 2'b00) resp_err_d = 1'b1;
          if (burst_idx_q == BIDX_W'(NUM_BURSTS - 1)) begin
            frame_done_d = 1'b1;
            burst_idx_d  = '0;
          end else begin
            burst_idx_d = burst_idx_q + 1'b1;
          end
          bu_state_d = BU_IDLE;
        end
      end
      default: bu_state_d = BU_IDLE;
    endcase
  end

  always_ff @(posedge oclk or negedge resetn) begin
    if (!resetn) begin
      bu_state_q   <= BU_IDLE;
      burst_idx_q  <= '0;
      beat_q       <= '0;
      awaddr_q     <= '0;
      frame_done_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      bu_state_q   <= bu_state_d;
      burst_idx_q  <= burst_idx_d;
      beat_q       <= beat_d;
      awaddr_q     <= awaddr_d;
      frame_done_q <= frame_done_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // An empty FIFO during a write burst can only mean the frame tail: emit pad beats.
  logic data_beat;
  assign data_beat = (bu_state_q == BU_W) && !fifo_empty;

  assign bus.mem_axi_awaddr  = awaddr_q;
  assign bus.mem_axi_awlen   = 8'(MEM_BURST_LEN - 1);
  assign bus.mem_axi_awsize  = 3'd2;
  assign bus.mem_axi_awburst = 2'b01;
  assign bus.mem_axi_awprot  = 3'b000;
  assign bus.mem_axi_awvalid = (bu_state_q == BU_AW);
  assign bus.mem_axi_wvalid  = (bu_state_q == BU_W);
  assign bus.mem_axi_wdata   = data_beat ? {8'h00, fifo_mem_q[rd_ptr_q]} : 32'h0;
  assign bus.mem_axi_wstrb   = data_beat ? 4'hF : 4'h0;
  assign bus.mem_axi_wlast   = (bu_state_q == BU_W) && last_beat;
  assign bus.mem_axi_bready  = (bu_state_q == BU_B);

  assign frame_done = frame_done_q;
  assign busy       = (in_state_q != IN_SYNC);
  assign sof_err    = sof_err_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_video_capture_dma.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_video_capture_dma : directed frames against an 8x2 and a 5x2 capture DMA
// Revision : 1.0
// -----------------------------------------------------------------------------
module tb_video_capture_dma;

  logic        oclk = 1'b0;
  logic        resetn;
  logic [31:0] cfg_startaddr;
  logic        sel;
  logic        s_tvalid;
  logic [23:0] s_tdata;
  logic        s_tuser;
  logic        awready, wready, b_en;
  int          err_aw_a, err_aw_b;

  logic fd_a, busy_a, sof_err_a, resp_err_a;
  logic fd_b, busy_b, sof_err_b, resp_err_b;

  always #5 oclk = ~oclk;

  video_capture_dma_if bus_a ();
  video_capture_dma_if bus_b ();

  video_capture_dma #(.HOR_PIXELS(8), .VER_PIXELS(2), .MEM_BURST_LEN(4), .FIFO_DEPTH(8)) u_dut_a (
    .oclk(oclk), .resetn(resetn), .cfg_startaddr(cfg_startaddr), .bus(bus_a),
    .frame_done(fd_a), .busy(busy_a), .sof_err(sof_err_a), .resp_err(resp_err_a));

  video_capture_dma #(.HOR_PIXELS(5), .VER_PIXELS(2), .MEM_BURST_LEN(4), .FIFO_DEPTH(8)) u_dut_b (
    .oclk(oclk), .resetn(resetn), .cfg_startaddr(cfg_startaddr), .bus(bus_b),
    .frame_done(fd_b), .busy(busy_b), .sof_err(sof_err_b), .resp_err(resp_err_b));

  int aw_cnt_a = 0, aw_cnt_b = 0;

  assign bus_a.in_axis_tvalid  = s_tvalid && !sel;
  assign bus_a.in_axis_tdata   = s_tdata;
  assign bus_a.in_axis_tuser   = s_tuser;
  assign bus_a.mem_axi_awready = awready;
  assign bus_a.mem_axi_wready  = wready;
  assign bus_a.mem_axi_bvalid  = bus_a.mem_axi_bready && b_en;
  assign bus_a.mem_axi_bresp   = (aw_cnt_a == err_aw_a) ? 2'd2 : 2'd0;

  assign bus_b.in_axis_tvalid  = s_tvalid && sel;
  assign bus_b.in_axis_tdata   = s_tdata;
  assign bus_b.in_axis_tuser   = s_tuser;
  assign bus_b.mem_axi_awready = awready;
  assign bus_b.mem_axi_wready  = wready;
  assign bus_b.mem_axi_bvalid  = bus_b.mem_axi_bready && b_en;
  assign bus_b.mem_axi_bresp   = (aw_cnt_b == err_aw_b) ? 2'd2 : 2'd0;

  logic w_tready;
  assign w_tready = sel ? bus_b.in_axis_tready : bus_a.in_axis_tready;

  // Bus monitor: records what the next rising edge will transfer
  logic [31:0] aw_a[$], aw_b[$];
  logic [36:0] w_a[$], w_b[$];
  int cyc = 0, acc_a = 0, fd_n_a = 0, fd_n_b = 0;
  int lastb_a = 0, lastb_b = 0, fd_cyc_a = 0, fd_cyc_b = 0;

  always @(negedge oclk) begin
    if (bus_a.in_axis_tvalid && bus_a.in_axis_tready) acc_a++;
    if (bus_a.mem_axi_awvalid && bus_a.mem_axi_awready) begin aw_a.push_back(bus_a.mem_axi_awaddr); aw_cnt_a++; end
    if (bus_b.mem_axi_awvalid && bus_b.mem_axi_awready) begin aw_b.push_back(bus_b.mem_axi_awaddr); aw_cnt_b++; end
    if (bus_a.mem_axi_wvalid && bus_a.mem_axi_wready)
      w_a.push_back({bus_a.mem_axi_wstrb, bus_a.mem_axi_wlast, bus_a.mem_axi_wdata});
    if (bus_b.mem_axi_wvalid && bus_b.mem_axi_wready)
      w_b.push_back({bus_b.mem_axi_wstrb, bus_b.mem_axi_wlast, bus_b.mem_axi_wdata});
    if (bus_a.mem_axi_bvalid && bus_a.mem_axi_bready) lastb_a = cyc;
    if (bus_b.mem_axi_bvalid && bus_b.mem_axi_bready) lastb_b = cyc;
    if (fd_a) begin fd_n_a++; fd_cyc_a = cyc; end
    if (fd_b) begin fd_n_b++; fd_cyc_b = cyc; end
    cyc++;
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_px(input logic [23:0] d, input logic u);
    int t;
    t = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    while (1) begin
      @(negedge oclk);
      if (w_tready) break;
      t++;
      if (t > 500) begin
        check("tready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge oclk); #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int npre, input int n, input logic [23:0] first, input int dup);
    for (int k = 0; k < npre; k++) send_px(24'hAA0000 + 24'(k), 1'b0);
    for (int i = 0; i < n; i++) send_px(first + 24'(i), (i == 0) || (i == dup));
  endtask

  task automatic wait_fd(input bit b, input int prev);
    int t;
    t = 0;
    while (((b ? fd_n_b : fd_n_a) <= prev) && (t < 3000)) begin
      @(negedge oclk);
      t++;
    end
    if (t >= 3000) check("frame_done_timeout", 64'd0, 64'd1);
    repeat (4) @(posedge oclk);
    #1;
  endtask

  // Expected memory image: data words then zero-strobe pads, wlast every 4th beat
  task automatic check_frame(input bit b, input int aw0, input int w0,
                             input logic [31:0] base, input logic [23:0] first, input int npix);
    int nb;
    logic [36:0] e, g;
    logic [31:0] ga;
    nb = (npix + 3) / 4;
    check("aw_count", 64'(b ? aw_b.size() - aw0 : aw_a.size() - aw0), 64'(nb));
    for (int k = 0; k < nb; k++) begin
      ga = '1;
      if (b && (aw0 + k < aw_b.size())) ga = aw_b[aw0 + k];
      if (!b && (aw0 + k < aw_a.size())) ga = aw_a[aw0 + k];
      check("awaddr", 64'(ga), 64'(base + 32'(16 * k)));
    end
    for (int i = 0; i < nb * 4; i++) begin
      if (i < npix) e = {4'hF, (i % 4 == 3), 8'h00, first + 24'(i)};
      else          e = {4'h0, (i % 4 == 3), 32'h0};
      g = '1;
      if (b && (w0 + i < w_b.size())) g = w_b[w0 + i];
      if (!b && (w0 + i < w_a.size())) g = w_a[w0 + i];
      check("wbeat", 64'(g), 64'(e));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, w0, fdn, acc0, awc0;
    resetn = 1'b0; sel = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0;
    awready = 1'b1; wready = 1'b1; b_en = 1'b1; cfg_startaddr = 32'h1000;
    err_aw_a = -1; err_aw_b = -1;

    // Reset values
    repeat (3) @(posedge oclk);
    #1;
    check("rst_tready", 64'(bus_a.in_axis_tready), 64'd0);
    check("rst_valids", 64'({bus_a.mem_axi_awvalid, bus_a.mem_axi_wvalid, bus_a.mem_axi_bready}), 64'd0);
    check("rst_awaddr", 64'(bus_a.mem_axi_awaddr), 64'd0);
    check("rst_wdata_wlast", 64'({bus_a.mem_axi_wdata, bus_a.mem_axi_wlast}), 64'd0);
    check("rst_status", 64'({fd_a, busy_a, sof_err_a, resp_err_a}), 64'd0);
    resetn = 1'b1;
    @(negedge oclk);
    check("tready_release_cycle", 64'(bus_a.in_axis_tready), 64'd0);
    @(posedge oclk); #1;
    check("tready_after_release", 64'(bus_a.in_axis_tready), 64'd1);
    check("awlen_awsize_awburst_awprot",
          64'({bus_a.mem_axi_awlen, bus_a.mem_axi_awsize, bus_a.mem_axi_awburst, bus_a.mem_axi_awprot}),
          64'({8'd3, 3'd2, 2'd1, 3'd0}));

    // 16-pixel frame, full throughput
    aw0 = aw_a.size(); w0 = w_a.size(); fdn = fd_n_a;
    send_frame(0, 16, 24'h000001, -1);
    check("busy_during_frame", 64'(busy_a), 64'd1);
    wait_fd(0, fdn);
    check_frame(0, aw0, w0, 32'h1000, 24'h000001, 16);
    check("fd_pulses", 64'(fd_n_a - fdn), 64'd1);
    check("fd_after_last_b", 64'(fd_cyc_a - lastb_a), 64'd1);
    check("busy_after_frame", 64'(busy_a), 64'd0);

    // 10-pixel frame: last burst padded
    sel = 1'b1;
    aw0 = aw_b.size(); w0 = w_b.size(); fdn = fd_n_b;
    send_frame(0, 10, 24'h000001, -1);
    wait_fd(1, fdn);
    check_frame(1, aw0, w0, 32'h1000, 24'h000001, 10);
    check("fd_pulses_b", 64'(fd_n_b - fdn), 64'd1);
    check("fd_after_last_b_b", 64'(fd_cyc_b - lastb_b), 64'd1);
    sel = 1'b0;

    // Pixels before SOF are dropped
    cfg_startaddr = 32'h2000;
    aw0 = aw_a.size(); w0 = w_a.size(); fdn = fd_n_a; acc0 = acc_a;
    send_frame(3, 16, 24'h000100, -1);
    wait_fd(0, fdn);
    check("pre_sof_accepted", 64'(acc_a - acc0), 64'd19);
    check_frame(0, aw0, w0, 32'h2000, 24'h000100, 16);

    // Back-pressure: wready low for 100 cycles
    cfg_startaddr = 32'h3000;
    aw0 = aw_a.size(); w0 = w_a.size(); fdn = fd_n_a; acc0 = acc_a;
    wready = 1'b0;
    fork
      send_frame(0, 16, 24'h000200, -1);
      begin
        repeat (60) @(negedge oclk);
        check("stall_tready", 64'(bus_a.in_axis_tready), 64'd0);
        check("stall_accepted", 64'(acc_a - acc0), 64'd8);
        check("stall_wvalid", 64'(bus_a.mem_axi_wvalid), 64'd1);
        repeat (40) @(posedge oclk);
        #1 wready = 1'b1;
      end
    join
    wait_fd(0, fdn);
    check_frame(0, aw0, w0, 32'h3000, 24'h000200, 16);

    // SOF mid-frame stored as data and flagged
    cfg_startaddr = 32'h4000;
    aw0 = aw_a.size(); w0 = w_a.size(); fdn = fd_n_a;
    check("sof_err_clear", 64'(sof_err_a), 64'd0);
    send_frame(0, 16, 24'h000300, 6);
    wait_fd(0, fdn);
    check("sof_err_set", 64'(sof_err_a), 64'd1);
    check_frame(0, aw0, w0, 32'h4000, 24'h000300, 16);

    // Error response on burst 2
    cfg_startaddr = 32'h5000;
    aw0 = aw_a.size(); w0 = w_a.size(); fdn = fd_n_a;
    err_aw_a = aw_cnt_a + 2;
    check("resp_err_clear", 64'(resp_err_a), 64'd0);
    send_frame(0, 16, 24'h000400, -1);
    wait_fd(0, fdn);
    err_aw_a = -1;
    check("resp_err_set", 64'(resp_err_a), 64'd1);
    check("fd_with_resp_err", 64'(fd_n_a - fdn), 64'd1);
    check_frame(0, aw0, w0, 32'h5000, 24'h000400, 16);

    // Asynchronous reset in the middle of a write burst
    wready = 1'b0;
    for (int i = 0; i < 4; i++) send_px(24'h000500 + 24'(i), i == 0);
    repeat (6) @(negedge oclk);
    check("midw_wvalid", 64'(bus_a.mem_axi_wvalid), 64'd1);
    check("midw_wdata", 64'(bus_a.mem_axi_wdata), 64'h500);
    #2 resetn = 1'b0;
    #1;
    check("arst_valids", 64'({bus_a.mem_axi_awvalid, bus_a.mem_axi_wvalid, bus_a.mem_axi_bready}), 64'd0);
    check("arst_tready", 64'(bus_a.in_axis_tready), 64'd0);
    check("arst_wdata_wlast_awaddr",
          64'({bus_a.mem_axi_wdata, bus_a.mem_axi_wlast}) | 64'(bus_a.mem_axi_awaddr), 64'd0);
    check("arst_status", 64'({fd_a, busy_a, sof_err_a, resp_err_a}), 64'd0);
    wready = 1'b1;
    @(posedge oclk); #1;
    resetn = 1'b1;
    awc0 = aw_cnt_a;
    repeat (6) @(posedge oclk);
    #1;
    check("post_rst_tready", 64'(bus_a.in_axis_tready), 64'd1);
    check("post_rst_no_burst", 64'(aw_cnt_a - awc0), 64'd0);
    check("post_rst_wvalid", 64'(bus_a.mem_axi_wvalid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
